// File: rtl/opb_register_ppc2simulink_pkg.sv
// Shared definitions for the OPB user registers (ppc2simulink and simulink2ppc):
// register offsets, attach-FSM state encodings and OPB <-> user bit-order helpers.
package opb_register_ppc2simulink_pkg;

   localparam logic REG_DATA  = 1'b0;
   localparam logic REG_COUNT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_HOLD = 2'd2
   } opb_state_e;

   // OPB numbers bits MSB-first, so OPB bit i lands on user bit 31-i by positional copy.
   function automatic logic [31:0] opb_to_user(input logic [0:31] opb);
      logic [31:0] user;
      user = opb;
      return user;
   endfunction

   function automatic logic [0:31] user_to_opb(input logic [31:0] user);
      logic [0:31] opb;
      opb = user;
      return opb;
   endfunction

   // BE[0] guards OPB byte 0, which is user byte lane 3 (bits 31:24).
   function automatic logic [3:0] be_to_user(input logic [0:3] be);
      logic [3:0] lanes;
      lanes = be;
      return lanes;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  lanes);
      logic [31:0] mask;
      mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
      return (new_v & mask) | (old_v & ~mask);
   endfunction

endpackage

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave exposing one byte-writable register to the fabric (DATA) plus a
// read-only count of DATA writes (COUNT); single-cycle ack with a hold state.
module opb_register_ppc2simulink
   import opb_register_ppc2simulink_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h00000000,
   parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex6"
) (
   input  logic        OPB_Clk,
   input  logic        OPB_Rst,
   input  logic [0:31] OPB_ABus,
   input  logic [0:3]  OPB_BE,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_RNW,
   input  logic        OPB_select,
   input  logic        OPB_seqAddr,
   output logic [0:31] Sl_DBus,
   output logic        Sl_xferAck,
   output logic        Sl_errAck,
   output logic        Sl_retry,
   output logic        Sl_toutSup,
   output logic [31:0] user_data_out,
   output logic        user_data_valid
);

   // Only the 32-bit OPB build exists; the family string is informational.
   if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 || C_FAMILY == "") begin : g_unsupported_cfg
   end

   opb_state_e  state_r;
   opb_state_e  next_state_s;
   logic        base_borrow_s;
   logic        high_borrow_s;
   logic        hit_s;
   logic        rnw_r;
   logic        offset_r;
   logic [3:0]  lanes_r;
   logic [31:0] wdata_r;
   logic [31:0] data_r;
   logic [31:0] count_r;
   logic        valid_r;
   logic        data_write_s;
   logic        xfer_ack_s;
   logic [31:0] rdata_s;
   logic        unused_s;

   assign unused_s = OPB_seqAddr;

   // Window check via 33-bit borrows so a zero base needs no constant compare.
   assign base_borrow_s = 1'(({1'b0, OPB_ABus} - {1'b0, C_BASEADDR}) >> 6'd32);
   assign high_borrow_s = 1'(({1'b0, C_HIGHADDR} - {1'b0, OPB_ABus}) >> 6'd32);
   assign hit_s         = OPB_select & ~base_borrow_s & ~high_borrow_s;

   // Attach FSM state register.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; HOLD ignores select so a slow-releasing master is not acked twice.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (hit_s) begin
               next_state_s = ST_ACK;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ACK:  next_state_s = ST_HOLD;
         ST_HOLD: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Output decode: ack and read data only in ACK, zero otherwise for the OR bus.
   always_comb begin
      xfer_ack_s = 1'b0;
      rdata_s    = 32'h0000_0000;
      case (state_r)
         ST_ACK: begin
            xfer_ack_s = 1'b1;
            if (rnw_r) begin
               rdata_s = (offset_r == REG_COUNT) ? count_r : data_r;
            end else begin
               rdata_s = 32'h0000_0000;
            end
         end
         default: begin
            xfer_ack_s = 1'b0;
            rdata_s    = 32'h0000_0000;
         end
      endcase
   end

   // Capture the request on the IDLE->ACK edge; ACK works only from these copies.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         rnw_r    <= 1'b0;
         offset_r <= REG_DATA;
         lanes_r  <= 4'h0;
         wdata_r  <= 32'h0000_0000;
      end else if (state_r == ST_IDLE && hit_s) begin
         rnw_r    <= OPB_RNW;
         offset_r <= OPB_ABus[29];
         lanes_r  <= be_to_user(OPB_BE);
         wdata_r  <= opb_to_user(OPB_DBus);
      end else begin
         rnw_r    <= rnw_r;
         offset_r <= offset_r;
         lanes_r  <= lanes_r;
         wdata_r  <= wdata_r;
      end
   end

   assign data_write_s = (state_r == ST_ACK) && !rnw_r && (offset_r == REG_DATA);

   // DATA/COUNT update; the strobe follows even for an all-lanes-off write.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         data_r  <= 32'h0000_0000;
         count_r <= 32'h0000_0000;
         valid_r <= 1'b0;
      end else if (data_write_s) begin
         data_r  <= merge_bytes(data_r, wdata_r, lanes_r);
         count_r <= count_r + 32'd1;
         valid_r <= 1'b1;
      end else begin
         data_r  <= data_r;
         count_r <= count_r;
         valid_r <= 1'b0;
      end
   end

   assign Sl_xferAck      = xfer_ack_s;
   assign Sl_DBus         = user_to_opb(rdata_s);
   assign Sl_errAck       = 1'b0;
   assign Sl_retry        = 1'b0;
   assign Sl_toutSup      = 1'b0;
   assign user_data_out   = data_r;
   assign user_data_valid = valid_r;

endmodule

// File: doc/opb_register_ppc2simulink.md
OPB_REGISTER_PPC2SIMULINK -- requirements
Module: opb_register_ppc2simulink

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h00000000, meaning first byte address of the slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h000000FF, meaning last byte address of the slave window.
REQ-003 SHALL have parameters C_OPB_AWIDTH=32 and C_OPB_DWIDTH=32 (OPB widths), and C_FAMILY="virtex6" (target family, informational only).
REQ-004 SHALL have a single clock, OPB_Clk (input, 1), and all logic SHALL be synchronous to its rising edge.
REQ-005 SHALL have OPB_Rst (input, 1), a synchronous, active-high reset.
REQ-006 SHALL have OPB_ABus (input, [0:31]): address.
REQ-007 SHALL have OPB_BE (input, [0:3]): byte enables; BE[0] covers DBus[0:7].
REQ-008 SHALL have OPB_DBus (input, [0:31]): write data.
REQ-009 SHALL have OPB_RNW (input, 1): 1 = read, 0 = write.
REQ-010 SHALL have OPB_select (input, 1): transfer request.
REQ-011 SHALL have OPB_seqAddr (input, 1): sequential hint, ignored.
REQ-012 SHALL have Sl_DBus (output, [0:31]): read data, and Sl_xferAck (output, 1): transfer acknowledge.
REQ-013 SHALL have Sl_errAck, Sl_retry and Sl_toutSup (output, 1 each), all tied to 0.
REQ-014 SHALL have user_data_out (output, [31:0]): the register value presented to the fabric.
REQ-015 SHALL have user_data_valid (output, 1): a one-cycle strobe on each update of user_data_out.

Function
REQ-016 SHALL map bits with OPB bit i equal to user bit 31-i, so DBus[0] is user MSB and BE[0] covers user[31:24].
REQ-017 SHALL decode a hit as OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word offset = OPB_ABus[29] (0 = DATA, 1 = COUNT).
REQ-018 SHALL implement the FSM IDLE -> ACK on a hit; ACK -> HOLD unconditionally; HOLD -> IDLE unconditionally.
REQ-019 SHALL assert Sl_xferAck only in ACK, for exactly 1 cycle, giving an access latency of 1 cycle from the sampled hit.
REQ-020 SHALL ignore OPB_select in HOLD, so that no double ack occurs while the master deasserts select.
REQ-021 SHALL, for a DATA write in ACK, update each byte of the register whose BE bit is 1 and hold bytes whose BE bit is 0.
REQ-022 SHALL, for a DATA write in ACK, update user_data_out at the same edge and pulse user_data_valid on the following cycle, even when all BE bits are 0.
REQ-023 SHALL maintain COUNT as a 32-bit read-only counter of DATA writes that wraps 0xFFFFFFFF -> 0; writes to COUNT SHALL be acked and ignored.
REQ-024 SHALL drive Sl_DBus with the selected register during ACK of a read and with all zeros otherwise (OR-bus rule), including during writes.
REQ-025 SHALL treat a miss (address outside the window) as no response: stay in IDLE, xferAck=0, Sl_DBus=0.
REQ-026 SHALL sample OPB_RNW, OPB_ABus, OPB_BE and OPB_DBus on the IDLE->ACK edge and use the registered copies in ACK.

Reset
REQ-027 SHALL, while OPB_Rst=1, set FSM=IDLE, the DATA register=0, COUNT=0, user_data_out=0, user_data_valid=0, Sl_xferAck=0 and Sl_DBus=0.
REQ-028 SHALL, when reset is asserted in ACK or HOLD, abort the transfer with no ack and no register update; reset SHALL take priority over all other events.

Structure
REQ-029 SHALL place register offsets (DATA=0, COUNT=1), FSM state encodings and the byte-lane mapping function in a shared include/package for reuse by the simulink2ppc register.
REQ-030 SHALL be a single module with no sub-modules; the OPB attach FSM SHALL be inline.

Verification
REQ-031 SHALL cover: reset, then a DATA write of 0xDEADBEEF with BE=1111 -> xferAck 1 cycle later, user_data_out=0xDEADBEEF, 1 valid strobe, COUNT=1.
REQ-032 SHALL cover: DATA=0xDEADBEEF, then a write of 0x11223344 with BE=0101 -> user_data_out=0xDE22BE44.
REQ-033 SHALL cover: a read of DATA then a read of COUNT -> Sl_DBus=0xDE22BE44 then 0x00000002, each only in its ack cycle, and 0 at all other times.
REQ-034 SHALL cover: a write and a read at C_HIGHADDR+4 -> no xferAck for 16 cycles and Sl_DBus=0.
REQ-035 SHALL cover: select held high for 6 cycles -> acks only on cycles 1 and 4 (IDLE/ACK/HOLD spacing), and never on consecutive cycles.
REQ-036 SHALL cover: COUNT preloaded to 0xFFFFFFFF by force, then a DATA write -> COUNT=0; and OPB_Rst asserted in ACK -> no strobe, DATA unchanged from reset.
